// File: rtl/if_pkg.sv
// Shared widths, step size and entry types for the pipelined instruction-fetch stage.
package if_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int INSTR_W_DEF = 32;
  localparam int PC_STEP     = 4;

  typedef enum logic {
    BR_REL = 1'b0,
    BR_ABS = 1'b1
  } br_mode_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, instr} entries with flush; pointers carry an extra MSB
// so full and empty are distinguished without a separate counter.
module fetch_queue
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = $bits(fetch_entry_t)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   head_valid,
  output logic [W-1:0]           head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         full;
  logic         empty;
  logic         do_push;
  logic         do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is cleared on reset so the head reads zero while reset is held.
  assign head_valid = !empty;
  assign head       = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/if_stage_pipelined.sv
// Instruction-fetch stage: credit-limited prefetch from an in-order, variable-latency
// memory into a fetch queue, with branch redirect and wrong-path response discard.
module if_stage_pipelined
  import if_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                INSTR_W   = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                Q_DEPTH   = 4,
  parameter int                MAX_OUTST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               br_taken,
  input  logic               br_abs,
  input  logic [ADDR_W-1:0]  br_pc,
  input  logic [ADDR_W-1:0]  br_offset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               out_ready
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = $clog2(Q_DEPTH) + 1;
  localparam int SW = ((OW > CW) ? OW : CW) + 1;
  localparam int EW = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [ADDR_W-1:0] br_target;
  logic [OW-1:0]     outst;
  logic [OW-1:0]     discard;
  logic [CW-1:0]     q_count;
  logic [SW-1:0]     credits_used;
  logic [EW-1:0]     q_head;
  logic              grant;
  logic              keep_rsp;
  logic              pop;
  br_mode_e          br_mode;

  assign br_mode = br_mode_e'(br_abs);

  always_comb begin
    br_target = {br_offset[ADDR_W-1:2], 2'b00};
    if (br_mode == BR_REL) br_target = br_pc + {br_offset[ADDR_W-3:0], 2'b00};
  end

  // Responses still owed to the queue hold a slot each; discarded ones do not.
  assign credits_used = SW'(q_count) + SW'(outst) - SW'(discard);

  assign imem_req  = rst && !br_taken && (outst < OW'(MAX_OUTST)) &&
                     (credits_used < SW'(Q_DEPTH));
  assign imem_addr = fetch_pc;
  assign grant     = imem_req && imem_gnt;
  assign keep_rsp  = imem_rvalid && !br_taken && (discard == '0);
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      outst    <= '0;
      discard  <= '0;
    end else begin
      if (br_taken) begin
        fetch_pc <= br_target;
        rsp_pc   <= br_target;
        discard  <= outst - OW'(imem_rvalid);
      end else begin
        if (grant) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        if (keep_rsp) rsp_pc <= rsp_pc + ADDR_W'(PC_STEP);
        if (imem_rvalid && (discard != '0)) discard <= discard - OW'(1);
      end
      outst <= outst + OW'(grant) - OW'(imem_rvalid);
    end
  end

  fetch_queue #(
    .DEPTH (Q_DEPTH),
    .W     (EW)
  ) u_fq (
    .clk        (clk),
    .rst_n      (rst),
    .push       (keep_rsp),
    .push_data  ({rsp_pc, imem_rdata}),
    .pop        (pop),
    .flush      (br_taken),
    .count      (q_count),
    .head_valid (out_valid),
    .head       (q_head)
  );

  assign out_pc    = q_head[EW-1:INSTR_W];
  assign out_instr = q_head[INSTR_W-1:0];

endmodule

// File: tb/tb_if_stage_pipelined.sv
// Directed bench for if_stage_pipelined: behavioural in-order memory with programmable
// latency, and a queue of expected PCs compared against every accepted output.
module tb_if_stage_pipelined;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        br_taken = 1'b0;
  logic        br_abs = 1'b0;
  logic [31:0] br_pc = '0;
  logic [31:0] br_offset = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 1'b0;

  always #5 clk = ~clk;

  if_stage_pipelined #(
    .ADDR_W    (32),
    .INSTR_W   (32),
    .RESET_PC  (32'h100),
    .Q_DEPTH   (4),
    .MAX_OUTST (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .br_taken    (br_taken),
    .br_abs      (br_abs),
    .br_pc       (br_pc),
    .br_offset   (br_offset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_ready   (out_ready)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] exp_q[$];
  int          n_pass = 0;
  int          n_chk = 0;
  int          cyc = 0;
  int          lat = 1;
  int          first_acc = -1;
  int          last_acc = -1;
  int          bcyc = 0;
  int          n = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic expect_seq(input logic [31:0] start, input int cnt);
    logic [31:0] pc;
    pc = start;
    for (int i = 0; i < cnt; i++) begin
      exp_q.push_back(pc);
      pc = pc + 32'd4;
    end
  endtask

  // One clock: sample handshakes before the edge, then present memory response for the next cycle.
  task automatic tick();
    mreq_t       r;
    logic [31:0] e;
    #1;
    if (dut.u_fq.push) check("push_not_full", dut.u_fq.full, 0);
    if (imem_req && imem_gnt) begin
      r.addr = imem_addr;
      r.due  = cyc + lat;
      mq.push_back(r);
    end
    if (br_taken) exp_q.delete();
    else if (out_valid && out_ready) begin
      check("out_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_entry", {out_pc, out_instr}, {e, mem_word(e)});
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_imem_req", imem_req, 0);

    // Streaming from RESET_PC with 1-cycle memory
    imem_gnt  = 1'b1;
    out_ready = 1'b1;
    lat       = 1;
    expect_seq(32'h100, 12);
    rst       = 1'b1;
    cyc       = 0;
    first_acc = -1;
    #1;
    check("first_req", {imem_req, imem_addr}, {1'b1, 32'h100});
    drain("stream", 40);
    check("stream_latency", first_acc, 2);
    check("stream_rate", last_acc - first_acc, 11);

    // Back-pressure: queue fills to exactly 4 and requests stop
    out_ready = 1'b0;
    repeat (10) tick();
    check("bp_req_dropped", imem_req, 0);
    check("bp_head_pc", {out_valid, out_pc}, {1'b1, 32'h130});
    check("bp_head_instr", out_instr, mem_word(32'h130));
    imem_gnt  = 1'b0;
    expect_seq(32'h130, 4);
    out_ready = 1'b1;
    repeat (4) tick();
    check("bp_released_all", exp_q.size(), 0);
    check("bp_queue_empty", out_valid, 0);

    // Grant withheld: address must hold
    for (int i = 0; i < 5; i++) begin
      check("stall_addr", {imem_req, imem_addr}, {1'b1, 32'h140});
      tick();
    end

    // Relative branch while streaming
    imem_gnt = 1'b1;
    expect_seq(32'h140, 3);
    drain("pre_rel", 20);
    br_taken  = 1'b1;
    br_abs    = 1'b0;
    br_pc     = 32'h200;
    br_offset = 32'h10;
    bcyc      = cyc;
    tick();
    br_taken  = 1'b0;
    first_acc = -1;
    #1;
    check("rel_req_target", {imem_req, imem_addr}, {1'b1, 32'h240});
    expect_seq(32'h240, 4);
    drain("rel", 20);
    check("rel_penalty", first_acc - bcyc, 3);

    // Absolute branch with three requests in flight on a 3-cycle memory
    out_ready = 1'b0;
    imem_gnt  = 1'b0;
    repeat (3) tick();
    lat       = 3;
    br_taken  = 1'b1;
    br_abs    = 1'b1;
    br_offset = 32'h800;
    tick();
    br_taken  = 1'b0;
    imem_gnt  = 1'b1;
    repeat (3) tick();
    imem_gnt  = 1'b0;
    check("abs_stale_rsp_present", imem_rvalid, 1);
    br_taken  = 1'b1;
    br_offset = 32'h1003;
    tick();
    br_taken  = 1'b0;
    imem_gnt  = 1'b1;
    out_ready = 1'b1;
    expect_seq(32'h1000, 3);
    drain("abs", 40);

    // Redirect coinciding with a response and a pop
    out_ready = 1'b0;
    lat       = 1;
    n         = 0;
    while (!(out_valid && imem_rvalid) && n < 20) begin
      tick();
      n++;
    end
    check("corner_setup", out_valid && imem_rvalid, 1);
    br_taken  = 1'b1;
    br_abs    = 1'b1;
    br_offset = 32'h300;
    out_ready = 1'b1;
    tick();
    br_taken  = 1'b0;
    out_ready = 1'b0;
    check("corner_q_empty", out_valid, 0);
    expect_seq(32'h300, 3);
    out_ready = 1'b1;
    drain("corner", 40);

    // Fetch PC wrap past the top of the address space
    out_ready = 1'b0;
    br_taken  = 1'b1;
    br_abs    = 1'b1;
    br_offset = 32'hFFFF_FFF8;
    tick();
    br_taken  = 1'b0;
    expect_seq(32'hFFFF_FFF8, 4);
    out_ready = 1'b1;
    drain("wrap", 40);

    // Relative branch with a negative word offset
    out_ready = 1'b0;
    br_taken  = 1'b1;
    br_abs    = 1'b0;
    br_pc     = 32'h200;
    br_offset = 32'hFFFF_FFFF;
    tick();
    br_taken  = 1'b0;
    expect_seq(32'h1FC, 3);
    out_ready = 1'b1;
    drain("rel_neg", 40);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    repeat (3) tick();
    check("pre_reset_valid", out_valid, 1);
    #3;
    rst = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_pc", out_pc, 0);
    check("arst_out_instr", out_instr, 0);
    check("arst_imem_req", imem_req, 0);
    mq.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    cyc       = 0;
    first_acc = -1;
    #1;
    check("restart_req", {imem_req, imem_addr}, {1'b1, 32'h100});
    expect_seq(32'h100, 4);
    out_ready = 1'b1;
    drain("restart", 30);
    check("restart_latency", first_acc, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
